// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit software registers (R/W or read-only per mask).
// Each accepted transfer is acked exactly once and followed by one dead cycle.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h01003400,
    parameter logic [31:0] C_HIGHADDR    = 32'h010034FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 4,
    parameter logic [31:0] C_RO_MASK     = 32'h0,
    parameter logic [31:0] C_RESET_VALUE = 32'h0,
    parameter string       C_FAMILY      = "virtex5"
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]  OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
    input  logic                       OPB_RNW,
    input  logic                       OPB_select,
    input  logic                       OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
    output logic                       Sl_errAck,
    output logic                       Sl_retry,
    output logic                       Sl_toutSup,
    output logic                       Sl_xferAck,
    output logic [C_NUM_REGS*32-1:0]   user_data_out,
    input  logic [C_NUM_REGS*32-1:0]   user_data_in,
    output logic [C_NUM_REGS-1:0]      user_update
);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             regs_q [C_NUM_REGS];
    logic [31:0]             regs_d [C_NUM_REGS];
    logic [31:0]             rdata_q, rdata_d;
    logic [C_NUM_REGS-1:0]   upd_q, upd_d;

    logic [31:0] addr, wdata, off;
    logic [3:0]  be;
    logic [29:0] idx;
    logic        hit, take;

    // Plain vector assignment maps OPB bit j onto user bit 31-j.
    assign addr  = OPB_ABus;
    assign wdata = OPB_DBus;
    assign be    = OPB_BE;
    assign off   = addr - C_BASEADDR;
    assign idx   = off[31:2];
    assign hit   = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign take  = (state_q == IDLE) && hit;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            upd_q   <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= C_RESET_VALUE;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            upd_q   <= upd_d;
            for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = ACK;
            ACK:     state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes commit and reads are captured on the same edge that accepts the hit.
    always_comb begin
        rdata_d = '0;
        upd_d   = '0;
        for (int i = 0; i < C_NUM_REGS; i++) regs_d[i] = regs_q[i];
        if (take) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (idx == 30'(i)) begin
                    if (OPB_RNW) begin
                        rdata_d = C_RO_MASK[i] ? user_data_in[32*i +: 32] : regs_q[i];
                    end else if (!C_RO_MASK[i]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[b]) regs_d[i][8*b +: 8] = wdata[8*b +: 8];
                        end
                        upd_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        Sl_xferAck  = (state_q == ACK);
        Sl_DBus     = (state_q == ACK) ? rdata_q : 32'h0;
        Sl_errAck   = 1'b0;
        Sl_retry    = 1'b0;
        Sl_toutSup  = 1'b0;
        user_update = upd_q;
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[32*g +: 32] = C_RO_MASK[g] ? 32'h0 : regs_q[g];
    end

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, off[1:0], user_data_in, (C_FAMILY == "")};

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised OPB slave exposing C_NUM_REGS 32-bit software registers to fabric logic, all on one clock. Each register is either read/write (PPC -> fabric, with byte-enable writes and a one-cycle update strobe) or read-only (fabric -> PPC status capture), selected per register by mask. It sits on the OPB bus alongside the other register and BRAM slaves and replaces groups of single-register slaves with one address window.

Parameters:
C_BASEADDR, 32'h01003400, first byte address of window
C_HIGHADDR, 32'h010034FF, last byte address of window
C_OPB_AWIDTH, 32, OPB address width (fixed 32)
C_OPB_DWIDTH, 32, OPB data width (fixed 32)
C_NUM_REGS, 4, number of registers, 1..32, word-spaced from C_BASEADDR
C_RO_MASK, 32'h0, bit i=1 -> register i read-only
C_RESET_VALUE, 32'h0, reset value of every read/write register
C_FAMILY, "virtex5", target family

Ports:
OPB_Clk  in  1  sole clock, rising edge
OPB_Rst  in  1  synchronous active-high reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables, BE[0] -> DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data, zero when not acking
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  transfer acknowledge
user_data_out  out  [C_NUM_REGS*32-1:0]  reg i at [32i+31:32i]
user_data_in  in  [C_NUM_REGS*32-1:0]  status for read-only regs, same packing
user_update  out  [C_NUM_REGS-1:0]  one-cycle pulse on committed write to reg i

Behaviour:
- Single clock OPB_Clk; reset synchronous, active-high on OPB_Rst.
- Reset: Sl_xferAck=0, Sl_DBus=0, user_update=0, state=IDLE, all R/W regs=C_RESET_VALUE; read-only slots of user_data_out drive 0 always.
- Bit mapping: OPB bit j <-> user bit 31-j; BE[0] covers user bits 31:24, BE[3] covers 7:0.
- Hit: OPB_select=1 and C_BASEADDR<=ABus<=C_HIGHADDR. Index = (ABus-C_BASEADDR)>>2; ABus[30:31] ignored.
- FSM: IDLE, ACK, HOLD.
  IDLE: hit sampled at edge k -> ACK. No hit -> stay.
  ACK (cycle k+1): Sl_xferAck=1 for exactly this cycle -> HOLD unconditionally.
  HOLD: one dead cycle, select ignored -> IDLE. Guarantees no double-ack while master drops select.
- Latency: ack one cycle after first sampled hit; minimum 3 cycles between acks.
- Write (RNW=0) to R/W index<C_NUM_REGS: enabled bytes latched at edge k, visible on user_data_out and user_update[i]=1 during ACK cycle; disabled bytes unchanged. BE=0000 still pulses user_update.
- Write to read-only index or index>=C_NUM_REGS: acked, no state change, no update pulse.
- Read (RNW=1): user_data_in slot (RO) or register (R/W) sampled at edge k, driven on Sl_DBus only during ACK; index>=C_NUM_REGS reads 0. Sl_DBus=0 in all other cycles.
- Reset during ACK or HOLD: next cycle Sl_xferAck=0, user_update=0, state=IDLE, registers reset; reset wins over a coincident write.
- Miss (address outside window): no ack, no bus drive; master times out.

Test Plan:
- Reset, then read idx0 (C_RESET_VALUE=32'hDEADBEEF) -> ack at k+1, Sl_DBus=32'hDEADBEEF, no update pulse.
- Write 32'h12345678 BE=1111 to idx2 -> user_data_out[95:64]=32'h12345678 and user_update=4'b0100 in ack cycle; then BE=0011 data 32'hAAAA5555 -> 32'h12345555.
- C_RO_MASK=32'h2, user_data_in[63:32]=32'hCAFE0001: read idx1 -> 32'hCAFE0001; write idx1 -> acked, user_update=0, user_data_out[63:32]=0.
- Select held high across 3 reads -> acks at k+1, k+4, k+7 only; Sl_DBus=0 outside ack cycles.
- Address C_BASEADDR+16 with C_NUM_REGS=4 read -> ack, data 0; address C_HIGHADDR+4 -> no ack for 16 cycles.
- Assert OPB_Rst in ACK cycle of a write -> next cycle ack=0, register=C_RESET_VALUE, FSM accepts a new read 1 cycle after reset release.
